// File: rtl/mem_write_monitor_pkg.sv
// Shared widths and types for the memory-write snoop/display path.
// Holds data width, history depth and derived index/count types.
package mem_write_monitor_pkg;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int NIBBLES = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [IDX_W:0]    cnt_t;

    function automatic logic [3:0] nib(word_t w, int i);
        return w[4*i +: 4];
    endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// Bus between the CPU snoop/board inputs and the display monitor.
// master: drives MemWrite/WriteData/StepBtn/Show; slave: drives display outputs.
interface mem_write_monitor_if;
    import mem_write_monitor_pkg::*;

    logic       MemWrite;
    word_t      WriteData;
    logic       StepBtn;
    logic       Show;
    logic [3:0] Number3;
    logic [3:0] Number2;
    logic [3:0] Number1;
    logic [3:0] Number0;
    logic       Button;
    logic       DC;
    idx_t       ViewIdx;
    logic       NewWrite;

    modport master (
        output MemWrite, WriteData, StepBtn, Show,
        input  Number3, Number2, Number1, Number0,
        input  Button, DC, ViewIdx, NewWrite
    );

    modport slave (
        input  MemWrite, WriteData, StepBtn, Show,
        output Number3, Number2, Number1, Number0,
        output Button, DC, ViewIdx, NewWrite
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw board button plus rising-edge pulse.
// Ports: clk_i, rst_ni (sync, active-low), btn_i (async), pulse_o (1 cycle).
module btn_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/mem_write_monitor.sv
// Snoops CPU data-memory writes into a small history and selects one for display.
// Ports: Clk, Reset_n (sync, active-low), bus (slave: snoop in, nibbles/flags out).
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mem_write_monitor_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    typedef logic [HOLD_W-1:0] hold_t;
    localparam hold_t HOLD_LOAD = hold_t'(HOLD_CYCLES - 1);

    word_t mem_q [DEPTH];
    idx_t  wr_ptr_q, wr_ptr_d;
    idx_t  view_q, view_d;
    cnt_t  count_q, count_d;
    hold_t hold_q, hold_d;
    logic  new_q, new_d;
    logic  button_q;
    logic  step_pulse;
    logic  empty;
    idx_t  rd_idx;
    word_t entry;
    cnt_t  view_nxt;

    btn_edge_sync u_step (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .btn_i   (bus.StepBtn),
        .pulse_o (step_pulse)
    );

    assign empty    = (count_q == '0);
    assign view_nxt = cnt_t'(view_q) + cnt_t'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        view_d   = view_q;
        hold_d   = hold_q;
        // NewWrite stays up for the cycle in which the counter reaches 0
        new_d    = (hold_q != '0);
        if (hold_q != '0)
            hold_d = hold_q - hold_t'(1);
        if (bus.MemWrite) begin
            wr_ptr_d = wr_ptr_q + idx_t'(1);
            if (count_q != cnt_t'(DEPTH))
                count_d = count_q + cnt_t'(1);
            view_d = '0;
            hold_d = HOLD_LOAD;
            new_d  = 1'b1;
        end else if (step_pulse && !empty) begin
            // wrap among valid entries only
            view_d = (view_nxt == count_q) ? '0 : view_q + idx_t'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            view_q   <= '0;
            hold_q   <= '0;
            new_q    <= 1'b0;
            button_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            view_q   <= view_d;
            hold_q   <= hold_d;
            new_q    <= new_d;
            button_q <= bus.Show;
        end
    end

    always_ff @(posedge Clk) begin
        if (bus.MemWrite)
            mem_q[wr_ptr_q] <= bus.WriteData;
    end

    // newest entry sits one slot behind the write pointer
    assign rd_idx = wr_ptr_q - idx_t'(1) - view_q;
    assign entry  = empty ? '0 : mem_q[rd_idx];

    assign bus.Number3  = nib(entry, 3);
    assign bus.Number2  = nib(entry, 2);
    assign bus.Number1  = nib(entry, 1);
    assign bus.Number0  = nib(entry, 0);
    assign bus.DC       = empty;
    assign bus.ViewIdx  = view_q;
    assign bus.NewWrite = new_q;
    assign bus.Button   = button_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Self-checking bench for mem_write_monitor: history model plus directed literals.
// Checks all display outputs every cycle against a queue-based model.
module tb_mem_write_monitor;
    import mem_write_monitor_pkg::*;

    localparam int HOLD = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    mem_write_monitor_if bus ();

    mem_write_monitor #(.HOLD_CYCLES(HOLD)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: newest-first history queue, view age, write age, button samples
    word_t hist[$];
    int    m_view = 0;
    int    since = 0;
    bit    wvalid = 0;
    bit    p1 = 0, p2 = 0, p3 = 0;
    bit    m_btn = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            m_view = 0;
            wvalid = 0;
            since  = 0;
            p1 = 0; p2 = 0; p3 = 0;
            m_btn = 0;
        end else begin
            bit step;
            // button first seen at edge e-2 and not at e-3 steps now
            step = p2 && !p3;
            p3 = p2; p2 = p1; p1 = bus.StepBtn;
            m_btn = bus.Show;
            if (bus.MemWrite) begin
                hist.push_front(bus.WriteData);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                m_view = 0;
                wvalid = 1;
                since  = 0;
            end else begin
                since++;
                if (step && hist.size() > 0)
                    m_view = (m_view + 1) % hist.size();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            word_t e;
            e = (hist.size() > 0) ? hist[m_view] : '0;
            chk("model_number",
                {16'h0, bus.Number3, bus.Number2, bus.Number1, bus.Number0}, e);
            chk("model_dc", bus.DC, hist.size() == 0);
            chk("model_viewidx", bus.ViewIdx, m_view);
            chk("model_newwrite", bus.NewWrite, wvalid && since < HOLD);
            chk("model_button", bus.Button, m_btn);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input word_t d);
        bus.MemWrite  = 1'b1;
        bus.WriteData = d;
        cyc(1);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic step();
        bus.StepBtn = 1'b1;
        cyc(3);
        bus.StepBtn = 1'b0;
        cyc(2);
    endtask

    function automatic logic [15:0] shown();
        return {bus.Number3, bus.Number2, bus.Number1, bus.Number0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        chk("rst_dc", bus.DC, 1);
        chk("rst_viewidx", bus.ViewIdx, 0);
        chk("rst_newwrite", bus.NewWrite, 0);
        chk("rst_number", shown(), 16'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.Show      = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.WriteData = '0;
        bus.StepBtn   = 1'b0;
        cyc(2);
        chk_en = 1;
        chk("init_dc", bus.DC, 1);
        chk("init_number", shown(), 16'h0);
        chk("init_newwrite", bus.NewWrite, 0);
        chk("init_viewidx", bus.ViewIdx, 0);
        chk("init_button", bus.Button, 0);
        rst_n = 1'b1;
        cyc(1);
        chk("button_on", bus.Button, 1);

        wr(16'hBEEF);
        chk("beef_number", shown(), 16'hBEEF);
        chk("beef_dc", bus.DC, 0);
        chk("beef_viewidx", bus.ViewIdx, 0);
        chk("beef_newwrite", bus.NewWrite, 1);
        cyc(7);
        chk("hold_last", bus.NewWrite, 1);
        cyc(1);
        chk("hold_fall", bus.NewWrite, 0);

        wr(16'h1111); wr(16'h2222); wr(16'h3333);
        wr(16'h4444); wr(16'h5555);
        chk("hist_new", shown(), 16'h5555);
        step();
        chk("step1_num", shown(), 16'h4444);
        chk("step1_idx", bus.ViewIdx, 1);
        step();
        chk("step2_num", shown(), 16'h3333);
        step();
        chk("step3_num", shown(), 16'h2222);
        chk("step3_idx", bus.ViewIdx, 3);
        step();
        chk("wrap4_num", shown(), 16'h5555);
        chk("wrap4_idx", bus.ViewIdx, 0);

        do_reset();
        step();
        chk("empty_step_idx", bus.ViewIdx, 0);
        chk("empty_step_dc", bus.DC, 1);
        wr(16'hAAAA); wr(16'hBBBB);
        chk("two_new", shown(), 16'hBBBB);
        step();
        chk("two_step1", shown(), 16'hAAAA);
        chk("two_step1_idx", bus.ViewIdx, 1);
        step();
        chk("two_wrap", shown(), 16'hBBBB);
        chk("two_wrap_idx", bus.ViewIdx, 0);

        bus.StepBtn = 1'b1;
        cyc(2);
        wr(16'h0C0D);
        chk("coll_idx", bus.ViewIdx, 0);
        chk("coll_num", shown(), 16'h0C0D);
        cyc(97);
        chk("coll_held_idx", bus.ViewIdx, 0);
        bus.StepBtn = 1'b0;
        cyc(3);
        bus.StepBtn = 1'b1;
        cyc(100);
        bus.StepBtn = 1'b0;
        cyc(3);
        chk("held_one_idx", bus.ViewIdx, 1);
        chk("held_one_num", shown(), 16'hBBBB);

        do_reset();
        cyc(1);
        wr(16'h1234);
        chk("post_rst_num", shown(), 16'h1234);
        step();
        chk("post_rst_idx", bus.ViewIdx, 0);
        chk("post_rst_dc", bus.DC, 0);

        cyc(2);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
